// File: rtl/image_window_container.sv
// image_window_container: banked row store that streams vertical WIN-row windows with edge handling
module image_window_container #(
  parameter int ROW_W     = 3072,
  parameter int ROWS      = 96,
  parameter int WIN       = 3,
  parameter int EDGE_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_start,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ROW_W-1:0]         wr_data,
  output logic                     loaded,
  input  logic                     win_start,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [WIN*ROW_W-1:0]     win_data,
  output logic [$clog2(ROWS)-1:0]  win_row,
  output logic                     win_last,
  output logic                     busy
);
  localparam int H     = (WIN - 1) / 2;
  localparam int DEPTH = ROWS / WIN;
  localparam int BW    = $clog2(WIN);
  localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int RW    = $clog2(ROWS);
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  state_t state, state_n;
  logic [ROW_W-1:0] mem [WIN][DEPTH];
  logic [ROW_W-1:0] q [WIN];
  logic [BW-1:0]    sel [WIN];
  logic [BW-1:0]    sel_n [WIN];
  logic [IW-1:0]    addr [WIN];
  logic [WIN-1:0]   zero, zero_n;
  logic [BW-1:0]    wb, cb;
  logic [IW-1:0]    wi, ci;
  logic [RW-1:0]    rc;
  logic             wr_go, wr_fire, sweep_go, rd_en;

  assign wr_go    = wr_start & ~busy;
  assign wr_ready = ~busy & ~loaded;
  assign wr_fire  = wr_valid & wr_ready & ~wr_go;
  assign sweep_go = (state == IDLE) & win_start & loaded;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // next-state: one read cycle in FILL, then stream until the last window is taken
  always_comb
    state_n = state == IDLE ? (sweep_go ? FILL : IDLE) :
              state == FILL ? STREAM :
              (win_ready & win_last ? IDLE : STREAM);

  // FSM outputs; a read is issued to prefetch the next window only when the current one is accepted
  always_comb begin
    busy      = state != IDLE;
    win_valid = state == STREAM;
    rd_en     = (state == FILL) | ((state == STREAM) & win_ready & ~win_last);
  end

  // per-slot bank/index of row rc-H+k, plus which bank output each slot shows and whether it is zeroed
  always_comb begin
    int r, bb, ii;
    zero_n = '0;
    for (int b = 0; b < WIN; b++) addr[b] = '0;
    for (int k = 0; k < WIN; k++) begin
      r  = int'(rc) + k - H;
      bb = int'(cb) + k - H;
      ii = int'(ci);
      if (bb < 0) begin
        bb += WIN;
        ii--;
      end else if (bb >= WIN) begin
        bb -= WIN;
        ii++;
      end
      zero_n[k] = (EDGE_MODE != 0) && (r < 0 || r >= ROWS);
      sel_n[k]  = r < 0 ? '0 : r >= ROWS ? BW'(WIN - 1) : BW'(bb);
      if (r >= 0 && r < ROWS) addr[BW'(bb)] = IW'(ii);
    end
  end

  // window output: each slot picks a bank read register (edge rows reuse row 0 / ROWS-1 already in the window)
  always_comb
    for (int k = 0; k < WIN; k++)
      win_data[k*ROW_W +: ROW_W] = zero[k] ? '0 : q[sel[k]];

  // read pointer and bank read registers; registers hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rc       <= '0;
      cb       <= '0;
      ci       <= '0;
      win_row  <= '0;
      win_last <= 1'b0;
      zero     <= '0;
      for (int k = 0; k < WIN; k++) begin
        q[k]   <= '0;
        sel[k] <= '0;
      end
    end else if (sweep_go) begin
      rc <= '0;
      cb <= '0;
      ci <= '0;
    end else if (rd_en) begin
      rc       <= rc + 1'b1;
      cb       <= cb == BW'(WIN - 1) ? '0 : cb + 1'b1;
      ci       <= ci + IW'(cb == BW'(WIN - 1));
      win_row  <= rc;
      win_last <= rc == RW'(ROWS - 1);
      zero     <= zero_n;
      for (int k = 0; k < WIN; k++) begin
        q[k]   <= mem[k][addr[k]];
        sel[k] <= sel_n[k];
      end
    end

  // write pointer and loaded flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb     <= '0;
      wi     <= '0;
      loaded <= 1'b0;
    end else if (wr_go) begin
      wb     <= '0;
      wi     <= '0;
      loaded <= 1'b0;
    end else if (wr_fire) begin
      wb <= wb == BW'(WIN - 1) ? '0 : wb + 1'b1;
      wi <= wi + IW'(wb == BW'(WIN - 1));
      if (wb == BW'(WIN - 1) && wi == IW'(DEPTH - 1)) loaded <= 1'b1;
    end

  // bank storage, not reset so data survives a reset
  always_ff @(posedge clk)
    if (wr_fire) mem[wb][wi] <= wr_data;
endmodule

// File: doc/image_window_container.md
IMAGE_WINDOW_CONTAINER -- requirements
Module: image_window_container

Interface
REQ-001 ROW_W, 3072, bits per image row.
REQ-002 ROWS, 96, rows stored; SHALL be a multiple of WIN.
REQ-003 WIN, 3, window height and bank count; SHALL be odd and >=3.
REQ-004 EDGE_MODE, 0, out-of-range rows: 0 = replicate edge row, 1 = zero fill.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_start  input  1  pulse: rewind write pointer to row 0 and clear loaded.
REQ-008 wr_valid  input  1  row write request.
REQ-009 wr_ready  output  1  write accepted when wr_valid & wr_ready.
REQ-010 wr_data  input  ROW_W  row data.
REQ-011 loaded  output  1  all ROWS rows written since last wr_start.
REQ-012 win_start  input  1  pulse: begin window sweep.
REQ-013 win_valid  output  1  win_data/win_row valid.
REQ-014 win_ready  input  1  consumer accepts the current window.
REQ-015 win_data  output  WIN*ROW_W  rows c-H..c+H, H=(WIN-1)/2; slot k is bits [k*ROW_W +: ROW_W] and holds row c-H+k.
REQ-016 win_row  output  clog2(ROWS)  center row c.
REQ-017 win_last  output  1  high with the window where c=ROWS-1.
REQ-018 busy  output  1  sweep in progress.

Function
REQ-019 Storage SHALL be WIN banks of ROWS/WIN rows each; row r in bank r mod WIN, index r div WIN, tracked by incrementing (bank, index) counters with no divider.
REQ-020 Bank reads SHALL be synchronous with 1-cycle latency; bank contents are not reset.
REQ-021 wr_ready SHALL equal !busy & !full; full = ROWS rows written since last wr_start.
REQ-022 Accepted write SHALL store wr_data at the write pointer and advance it; bank wraps WIN-1->0 with index+1.
REQ-023 loaded SHALL rise the cycle after the ROWS-th accepted write; further writes stall until wr_start.
REQ-024 wr_start coincident with wr_valid: wr_start wins, no write performed; wr_start while busy SHALL be ignored.
REQ-025 FSM states IDLE, FILL, STREAM; IDLE->FILL on win_start & loaded; win_start when !loaded or busy SHALL be ignored.
REQ-026 FILL SHALL issue bank reads for c=0 then go to STREAM; first win_valid 2 cycles after win_start.
REQ-027 STREAM: win_valid held with stable win_data/win_row until win_ready; each accept advances c by 1; throughput one window per cycle while win_ready is held high.
REQ-028 win_ready low SHALL stall without losing or reordering windows (output register plus prefetch hold).
REQ-029 Slot with row c-H+k<0 or >=ROWS: EDGE_MODE 0 SHALL output row 0 or row ROWS-1 respectively; EDGE_MODE 1 SHALL output all zeros.
REQ-030 Accept with win_last SHALL return to IDLE; win_valid=0 and busy=0 next cycle.
REQ-031 busy SHALL be high from the cycle after an accepted win_start until the return to IDLE.

Reset
REQ-032 rst_n low SHALL immediately force IDLE and clear win_valid, win_last, busy, loaded, win_row, win_data and the write pointer; wr_ready=1 after release.
REQ-033 Reset mid-sweep or mid-load SHALL abort the operation; bank data is retained but loaded=0 until a full reload.

Verification (ROW_W=8, ROWS=6, WIN=3; windows listed {slot0,slot1,slot2})
REQ-034 wr_start, then write rows 0x10..0x15 -> loaded=1 the cycle after the 6th write; a 7th wr_valid sees wr_ready=0.
REQ-035 EDGE_MODE 0, win_start, win_ready=1 -> first window 2 cycles later, then back-to-back: c0 {10,10,11}, c1 {10,11,12}, ..., c5 {14,15,15} with win_last=1; busy then falls.
REQ-036 EDGE_MODE 1, same stimulus -> c0 {00,10,11}, c5 {14,15,00}.
REQ-037 win_ready randomly toggled -> same sequence as REQ-035, each window stable while stalled, none skipped or duplicated.
REQ-038 win_start before loaded -> ignored, busy=0; wr_valid during a sweep -> wr_ready=0, memory unchanged.
REQ-039 rst_n low at c=3 -> win_valid, busy and loaded go to 0 immediately; reload and sweep reproduce REQ-035.
